// File: rtl/tdm_mux_8_1.sv
// Serialises an 8-bit word onto a single data line plus 3-bit channel select,
// skipping channels whose enable bit is clear; paced by a load/ready/done handshake.
module tdm_mux_8_1 #(
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] d,
  input  logic [7:0] en_mask,
  output logic       ready,
  output logic       I,
  output logic [2:0] s,
  output logic       valid,
  output logic       done
);

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

  localparam logic [7:0] HoldMax = 8'(HOLD_CYCLES - 1);

  state_e     state_q;
  logic [7:0] d_q;
  logic [7:0] mask_q;
  logic [2:0] ch_q;
  logic [7:0] hold_q;

  logic [7:0] rest_mask;
  logic [2:0] next_ch;
  logic [2:0] first_ch;

  function automatic logic [2:0] lowest_bit(input logic [7:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Candidates strictly above the current channel; no wrap past channel 7.
  always_comb begin
    rest_mask = mask_q & (8'hFF << (4'(ch_q) + 4'd1));
    next_ch   = lowest_bit(rest_mask);
    first_ch  = lowest_bit(en_mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      d_q     <= 8'h00;
      mask_q  <= 8'h00;
      ch_q    <= 3'd0;
      hold_q  <= 8'h00;
      ready   <= 1'b1;
      I       <= 1'b0;
      s       <= 3'd0;
      valid   <= 1'b0;
      done    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load) begin
            d_q    <= d;
            mask_q <= en_mask;
            hold_q <= 8'h00;
            ready  <= 1'b0;
            if (en_mask != 8'h00) begin
              state_q <= StSend;
              ch_q    <= first_ch;
              s       <= first_ch;
              I       <= d[first_ch];
              valid   <= 1'b1;
            end else begin
              state_q <= StDone;
              done    <= 1'b1;
            end
          end
        end
        StSend: begin
          if (hold_q == HoldMax) begin
            hold_q <= 8'h00;
            if (rest_mask != 8'h00) begin
              ch_q <= next_ch;
              s    <= next_ch;
              I    <= d_q[next_ch];
            end else begin
              state_q <= StDone;
              valid   <= 1'b0;
              I       <= 1'b0;
              s       <= 3'd0;
              done    <= 1'b1;
            end
          end else begin
            hold_q <= hold_q + 8'd1;
          end
        end
        StDone: begin
          done    <= 1'b0;
          ready   <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_mux_8_1.sv
// Directed and randomised checks of tdm_mux_8_1 with HOLD_CYCLES of 1 and 3;
// a behavioural demux_1_8 rebuilds words at the receive side.
module tb_tdm_mux_8_1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load1 = 1'b0, load3 = 1'b0;
  logic [7:0] d1 = 8'h00, m1 = 8'h00, d3 = 8'h00, m3 = 8'h00;
  logic       ready1, I1, valid1, done1;
  logic       ready3, I3, valid3, done3;
  logic [2:0] s1, s3;
  logic [7:0] y;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  tdm_mux_8_1 #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .load(load1), .d(d1), .en_mask(m1),
    .ready(ready1), .I(I1), .s(s1), .valid(valid1), .done(done1)
  );

  tdm_mux_8_1 #(.HOLD_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .load(load3), .d(d3), .en_mask(m3),
    .ready(ready3), .I(I3), .s(s3), .valid(valid3), .done(done3)
  );

  // demux_1_8 model: y[s] = I while the line is live
  assign y = valid1 ? (8'(I1) << s1) : 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks one live cycle of dut1.
  task automatic chk1(input string tag, input logic [2:0] es, input logic ei);
    check({tag, "_valid"}, valid1, 1'b1);
    check({tag, "_s"}, s1, es);
    check({tag, "_I"}, I1, ei);
    check({tag, "_ready"}, ready1, 1'b0);
  endtask

  task automatic chk3(input string tag, input logic [2:0] es, input logic ei);
    check({tag, "_valid"}, valid3, 1'b1);
    check({tag, "_s"}, s3, es);
    check({tag, "_I"}, I3, ei);
    check({tag, "_done"}, done3, 1'b0);
  endtask

  task automatic load_word1(input logic [7:0] dv, input logic [7:0] mv);
    d1 = dv; m1 = mv; load1 = 1'b1;
    step();
    load1 = 1'b0;
  endtask

  logic [7:0] exp_i = 8'hA5;
  logic [7:0] rx, seen, wd, wm;
  bit         got_done;

  initial begin
    step();
    step();
    rst = 1'b0;
    check("rst_ready", ready1, 1'b1);
    check("rst_valid", valid1, 1'b0);
    check("rst_I", I1, 1'b0);
    check("rst_s", s1, 3'd0);
    check("rst_done", done1, 1'b0);
    check("rst_ready3", ready3, 1'b1);

    // Full mask, d = A5
    load_word1(8'hA5, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      chk1($sformatf("full_ch%0d", i), 3'(i), exp_i[i]);
      step();
    end
    check("full_done", done1, 1'b1);
    check("full_done_valid", valid1, 1'b0);
    check("full_done_ready", ready1, 1'b0);
    step();
    check("full_ready", ready1, 1'b1);
    check("full_done_low", done1, 1'b0);

    // Sparse mask 1001_0010, d = 12
    load_word1(8'h12, 8'h92);
    chk1("sparse_c1", 3'd1, 1'b1);
    step();
    chk1("sparse_c4", 3'd4, 1'b1);
    step();
    chk1("sparse_c7", 3'd7, 1'b0);
    step();
    check("sparse_done", done1, 1'b1);
    check("sparse_valid", valid1, 1'b0);
    step();
    check("sparse_ready", ready1, 1'b1);

    // Empty mask
    load_word1(8'hFF, 8'h00);
    check("empty_done", done1, 1'b1);
    check("empty_valid", valid1, 1'b0);
    check("empty_ready_low", ready1, 1'b0);
    step();
    check("empty_ready", ready1, 1'b1);
    check("empty_done_low", done1, 1'b0);
    check("empty_valid2", valid1, 1'b0);

    // HOLD_CYCLES = 3, mask 81, d = 80; a second load mid-transfer is ignored
    d3 = 8'h80; m3 = 8'h81; load3 = 1'b1;
    step();
    load3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        d3 = 8'h7F; m3 = 8'hFF; load3 = 1'b1;
      end
      chk3($sformatf("h3_c0_%0d", i), 3'd0, 1'b0);
      step();
    end
    load3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk3($sformatf("h3_c7_%0d", i), 3'd7, 1'b1);
      step();
    end
    check("h3_done", done3, 1'b1);
    check("h3_done_valid", valid3, 1'b0);
    step();
    check("h3_ready", ready3, 1'b1);
    check("h3_done_low", done3, 1'b0);
    step();
    check("h3_no_second", valid3, 1'b0);
    check("h3_idle_ready", ready3, 1'b1);

    // Reset during the third channel of a full transfer
    load_word1(8'hA5, 8'hFF);
    chk1("rst_mid_c0", 3'd0, 1'b1);
    step();
    chk1("rst_mid_c1", 3'd1, 1'b0);
    step();
    chk1("rst_mid_c2", 3'd2, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_valid", valid1, 1'b0);
    check("rst_mid_I", I1, 1'b0);
    check("rst_mid_s", s1, 3'd0);
    check("rst_mid_ready", ready1, 1'b1);
    check("rst_mid_done", done1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst_mid_nodone%0d", i), done1, 1'b0);
    end
    load_word1(8'h3C, 8'hF0);
    chk1("post_rst_c4", 3'd4, 1'b1);
    step();
    chk1("post_rst_c5", 3'd5, 1'b1);
    for (int i = 0; i < 3; i++) step();
    check("post_rst_done", done1, 1'b1);
    step();
    check("post_rst_ready", ready1, 1'b1);

    // Reset and load together: load is dropped
    rst = 1'b1; d1 = 8'hFF; m1 = 8'hFF; load1 = 1'b1;
    step();
    rst = 1'b0; load1 = 1'b0;
    check("rst_load_ready", ready1, 1'b1);
    check("rst_load_valid", valid1, 1'b0);
    step();
    check("rst_load_valid2", valid1, 1'b0);
    check("rst_load_done", done1, 1'b0);

    // Random words rebuilt through the demux model
    for (int w = 0; w < 1000; w++) begin
      wd = 8'($urandom);
      wm = 8'($urandom);
      rx = 8'h00;
      seen = 8'h00;
      got_done = 1'b0;
      load_word1(wd, wm);
      for (int c = 0; c < 12 && !got_done; c++) begin
        if (done1) got_done = 1'b1;
        else begin
          if (valid1) begin
            rx[s1] = y[s1];
            seen[s1] = 1'b1;
          end
          step();
        end
      end
      check($sformatf("rnd%0d_done", w), got_done, 1'b1);
      check($sformatf("rnd%0d_data", w), rx & wm, wd & wm);
      check($sformatf("rnd%0d_chans", w), seen, wm);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
